// File: rtl/dutb_param_pkg.sv
// Shared dutb parameters and types, including the fail-monitor defaults and FSM state type.
package dutb_param_pkg;

   localparam int DUTB_MON_CH_NUM       = 4;
   localparam int DUTB_MON_DATA_WIDTH   = 16;
   localparam int DUTB_MON_EXP_DEPTH    = 8;
   localparam int DUTB_MON_MAX_FAIL_NUM = 16;
   localparam int DUTB_MON_STOP_MODE    = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      STOPPED = 2'd2
   } dutb_mon_state_t;

endpackage

// File: rtl/dutb_exp_fifo.sv
// Per-channel expected-word FIFO; pointers carry a wrap bit to tell full from empty.
module dutb_exp_fifo #(
   parameter int P_WIDTH = 16,
   parameter int P_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               push,
   input  logic               pop,
   input  logic [P_WIDTH-1:0] wr_data,
   output logic               full,
   output logic               empty,
   output logic [P_WIDTH-1:0] head
);

   localparam int AW = $clog2(P_DEPTH);

   logic [P_WIDTH-1:0] mem [P_DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/dutb_fail_monitor.sv
// Multi-channel pass/fail monitor: in-order compare of DUT words against buffered expected words.
//
// state   | meaning
// IDLE    | expected words accepted, dut_valid ignored
// RUN     | dut_valid compared against FIFO heads, counters update
// STOPPED | fail limit reached; counters and FIFOs frozen until clr/reset
module dutb_fail_monitor
   import dutb_param_pkg::*;
#(
   parameter int  P_CH_NUM       = DUTB_MON_CH_NUM,
   parameter int  P_DATA_WIDTH   = DUTB_MON_DATA_WIDTH,
   parameter int  P_EXP_DEPTH    = DUTB_MON_EXP_DEPTH,
   parameter int  P_MAX_FAIL_NUM = DUTB_MON_MAX_FAIL_NUM,
   parameter int  P_STOP_MODE    = DUTB_MON_STOP_MODE,
   localparam int FW             = $clog2(P_MAX_FAIL_NUM + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             clr,
   input  logic [P_CH_NUM-1:0]              exp_valid,
   input  logic [P_CH_NUM*P_DATA_WIDTH-1:0] exp_data,
   output logic [P_CH_NUM-1:0]              exp_ready,
   input  logic [P_CH_NUM-1:0]              dut_valid,
   input  logic [P_CH_NUM*P_DATA_WIDTH-1:0] dut_data,
   output logic [FW-1:0]                    fail_cnt,
   output logic [31:0]                      pass_cnt,
   output logic [P_CH_NUM-1:0]              fail_mask,
   output logic [P_CH_NUM-1:0]              underflow,
   output logic                             stop,
   output logic [1:0]                       state
);

   localparam int SW = FW + 5;

   dutb_mon_state_t   state_q, state_nxt;
   logic              run;
   logic [P_CH_NUM-1:0] full, empty, push, pop, chk, pass_v, fail_v, uflow_v;
   logic [P_DATA_WIDTH-1:0] head [P_CH_NUM];
   logic [4:0]        n_pass, n_fail;
   logic [SW-1:0]     fail_sum;
   logic [FW-1:0]     fail_cnt_nxt;
   logic              limit_hit;

   assign run   = (state_q == RUN);
   assign state = state_q;

   for (genvar i = 0; i < P_CH_NUM; i++) begin : g_ch
      assign exp_ready[i] = !full[i] && (state_q != STOPPED);
      assign push[i]      = exp_valid[i] && exp_ready[i];
      assign chk[i]       = run && dut_valid[i];
      // Head is taken from registered occupancy, so a same-cycle push into empty is an underflow.
      assign pop[i]       = chk[i] && !empty[i];
      assign uflow_v[i]   = chk[i] && empty[i];
      assign pass_v[i]    = pop[i] && (head[i] == dut_data[i*P_DATA_WIDTH +: P_DATA_WIDTH]);
      assign fail_v[i]    = chk[i] && !pass_v[i];

      dutb_exp_fifo #(
         .P_WIDTH (P_DATA_WIDTH),
         .P_DEPTH (P_EXP_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (clr),
         .push    (push[i]),
         .pop     (pop[i]),
         .wr_data (exp_data[i*P_DATA_WIDTH +: P_DATA_WIDTH]),
         .full    (full[i]),
         .empty   (empty[i]),
         .head    (head[i])
      );
   end

   always_comb begin
      n_pass = '0;
      n_fail = '0;
      for (int i = 0; i < P_CH_NUM; i++) begin
         n_pass = n_pass + 5'(pass_v[i]);
         n_fail = n_fail + 5'(fail_v[i]);
      end
      fail_sum     = SW'(fail_cnt) + SW'(n_fail);
      limit_hit    = run && (fail_sum >= SW'(P_MAX_FAIL_NUM));
      fail_cnt_nxt = (fail_sum >= SW'(P_MAX_FAIL_NUM)) ? FW'(P_MAX_FAIL_NUM) : fail_sum[FW-1:0];
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (en) state_nxt = RUN;
         RUN: begin
            if (limit_hit && (P_STOP_MODE == 1)) state_nxt = STOPPED;
            else if (!en)                        state_nxt = IDLE;
         end
         STOPPED: state_nxt = STOPPED;
         default: state_nxt = IDLE;
      endcase
      if (clr) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_cnt  <= '0;
         pass_cnt  <= '0;
         fail_mask <= '0;
         underflow <= '0;
         stop      <= 1'b0;
      end else if (clr) begin
         fail_cnt  <= '0;
         pass_cnt  <= '0;
         fail_mask <= '0;
         underflow <= '0;
         stop      <= 1'b0;
      end else begin
         underflow <= uflow_v;
         if (run) begin
            fail_cnt  <= fail_cnt_nxt;
            pass_cnt  <= pass_cnt + 32'(n_pass);
            fail_mask <= fail_mask | fail_v;
         end
         if (limit_hit) stop <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dutb_fail_monitor.sv
// Bench for dutb_fail_monitor: a saturating instance (limit 16) and a halting instance (limit 4)
// share one stimulus stream and are both checked every cycle against a queue-based model.
module tb_dutb_fail_monitor;

   localparam int CH = 4;
   localparam int W  = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic [CH-1:0] exp_valid = '0;
   logic [CH*W-1:0] exp_data = '0;
   logic [CH-1:0] dut_valid = '0;
   logic [CH*W-1:0] dut_data = '0;

   logic [CH-1:0] exp_ready_a, exp_ready_b;
   logic [4:0]    fail_cnt_a;
   logic [2:0]    fail_cnt_b;
   logic [31:0]   pass_cnt_a, pass_cnt_b;
   logic [CH-1:0] fail_mask_a, fail_mask_b, underflow_a, underflow_b;
   logic          stop_a, stop_b;
   logic [1:0]    state_a, state_b;

   int total = 0;
   int bad = 0;

   logic [W-1:0] mq [2][CH][$];
   int           mst [2];
   int           mfc [2];
   int           mpc [2];
   logic [CH-1:0] mmask [2];
   logic [CH-1:0] muf [2];
   bit           mstop [2];
   int           mmax [2] = '{16, 4};
   int           mmode [2] = '{0, 1};

   always #5 clk = ~clk;

   dutb_fail_monitor #(.P_CH_NUM(CH), .P_DATA_WIDTH(W), .P_EXP_DEPTH(DEPTH),
                       .P_MAX_FAIL_NUM(16), .P_STOP_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready_a),
      .dut_valid(dut_valid), .dut_data(dut_data),
      .fail_cnt(fail_cnt_a), .pass_cnt(pass_cnt_a), .fail_mask(fail_mask_a),
      .underflow(underflow_a), .stop(stop_a), .state(state_a));

   dutb_fail_monitor #(.P_CH_NUM(CH), .P_DATA_WIDTH(W), .P_EXP_DEPTH(DEPTH),
                       .P_MAX_FAIL_NUM(4), .P_STOP_MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready_b),
      .dut_valid(dut_valid), .dut_data(dut_data),
      .fail_cnt(fail_cnt_b), .pass_cnt(pass_cnt_b), .fail_mask(fail_mask_b),
      .underflow(underflow_b), .stop(stop_b), .state(state_b));

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic model_clear(input int d);
      for (int c = 0; c < CH; c++) mq[d][c].delete();
      mst[d] = 0; mfc[d] = 0; mpc[d] = 0;
      mmask[d] = '0; muf[d] = '0; mstop[d] = 1'b0;
   endtask

   function automatic logic [CH-1:0] model_rdy(input int d);
      logic [CH-1:0] r;
      for (int c = 0; c < CH; c++) r[c] = (mq[d][c].size() < DEPTH) && (mst[d] != 2);
      return r;
   endfunction

   // One clock of the monitor's rules, applied to the inputs currently driven.
   task automatic model_step(input int d);
      logic [CH-1:0] rdy, fv, uv;
      logic [W-1:0]  w;
      int            nf, np;
      bit            hit;
      rdy = model_rdy(d);
      if (clr) begin
         model_clear(d);
         return;
      end
      nf = 0; np = 0; fv = '0; uv = '0;
      if (mst[d] == 1) begin
         for (int c = 0; c < CH; c++) begin
            if (dut_valid[c]) begin
               if (mq[d][c].size() == 0) begin
                  nf++; fv[c] = 1'b1; uv[c] = 1'b1;
               end else begin
                  w = mq[d][c].pop_front();
                  if (w == dut_data[c*W +: W]) np++;
                  else begin nf++; fv[c] = 1'b1; end
               end
            end
         end
      end
      for (int c = 0; c < CH; c++)
         if (exp_valid[c] && rdy[c]) mq[d][c].push_back(exp_data[c*W +: W]);
      muf[d] = uv;
      if (mst[d] == 1) begin
         hit = (mfc[d] + nf) >= mmax[d];
         mfc[d] = hit ? mmax[d] : mfc[d] + nf;
         mpc[d] += np;
         mmask[d] |= fv;
         if (hit) mstop[d] = 1'b1;
         if (hit && mmode[d] == 1) mst[d] = 2;
         else if (!en)             mst[d] = 0;
      end else if (mst[d] == 0 && en) begin
         mst[d] = 1;
      end
   endtask

   task automatic check_all();
      chk("state",     0, 32'(state_a),     32'(mst[0]));
      chk("state",     1, 32'(state_b),     32'(mst[1]));
      chk("fail_cnt",  0, 32'(fail_cnt_a),  32'(mfc[0]));
      chk("fail_cnt",  1, 32'(fail_cnt_b),  32'(mfc[1]));
      chk("pass_cnt",  0, pass_cnt_a,       32'(mpc[0]));
      chk("pass_cnt",  1, pass_cnt_b,       32'(mpc[1]));
      chk("fail_mask", 0, 32'(fail_mask_a), 32'(mmask[0]));
      chk("fail_mask", 1, 32'(fail_mask_b), 32'(mmask[1]));
      chk("underflow", 0, 32'(underflow_a), 32'(muf[0]));
      chk("underflow", 1, 32'(underflow_b), 32'(muf[1]));
      chk("exp_ready", 0, 32'(exp_ready_a), 32'(model_rdy(0)));
      chk("exp_ready", 1, 32'(exp_ready_b), 32'(model_rdy(1)));
      chk("stop",      1, 32'(stop_b),      32'(mstop[1]));
   endtask

   task automatic cyc();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Drive a channel's DUT word from the saturating model's head (or garbage if empty).
   task automatic drive_match(input int c, input bit corrupt);
      logic [W-1:0] w;
      w = (mq[0][c].size() != 0) ? mq[0][c][0] : 16'($urandom);
      dut_data[c*W +: W] = corrupt ? (w ^ 16'h0001) : w;
   endtask

   initial begin
      int ucnt;
      model_clear(0);
      model_clear(1);
      repeat (3) @(posedge clk);
      #1;
      check_all();
      chk("reset_ready", 0, 32'(exp_ready_a), 32'hF);
      rst_n = 1'b1;

      // Two channels, eight matching words each.
      en = 1'b1;
      cyc();
      exp_valid = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         exp_data = {$urandom, $urandom};
         cyc();
      end
      exp_valid = '0;
      chk("fifo_full_ready", 0, 32'(exp_ready_a), 32'hC);
      dut_valid = 4'b0011;
      for (int k = 0; k < 8; k++) begin
         drive_match(0, 1'b0);
         drive_match(1, 1'b0);
         cyc();
      end
      dut_valid = '0;
      cyc();
      chk("match_pass", 0, pass_cnt_a, 32'd16);
      chk("match_fail", 0, 32'(fail_cnt_a), 32'd0);
      chk("match_stop", 1, 32'(stop_b), 32'd0);

      // Ch0 word 3 corrupted, ch1 five compares against an empty FIFO.
      exp_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         exp_data = {$urandom, $urandom};
         cyc();
      end
      exp_valid = '0;
      dut_valid = 4'b0011;
      ucnt = 0;
      for (int k = 0; k < 5; k++) begin
         drive_match(0, k == 3);
         dut_data[W +: W] = 16'($urandom);
         cyc();
         if (underflow_a[1]) ucnt++;
      end
      dut_valid = '0;
      cyc();
      chk("mix_fail_cnt", 0, 32'(fail_cnt_a), 32'd6);
      chk("mix_uf_pulses", 0, 32'(ucnt), 32'd5);
      chk("mix_fail_mask", 0, 32'(fail_mask_a), 32'h3);
      chk("mix_halted", 1, 32'(state_b), 32'd2);

      // Four channels fail together against a limit of four.
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      cyc();
      dut_valid = 4'hF;
      cyc();
      chk("burst_fail_cnt", 1, 32'(fail_cnt_b), 32'd4);
      chk("burst_stop", 1, 32'(stop_b), 32'd1);
      chk("burst_ready", 1, 32'(exp_ready_b), 32'd0);
      for (int k = 0; k < 6; k++) begin
         dut_valid = 4'($urandom);
         exp_valid = 4'($urandom);
         exp_data  = {$urandom, $urandom};
         dut_data  = {$urandom, $urandom};
         cyc();
      end
      dut_valid = '0;
      exp_valid = '0;
      chk("frozen_fail_cnt", 1, 32'(fail_cnt_b), 32'd4);
      chk("frozen_pass_cnt", 1, pass_cnt_b, 32'd0);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_stopped_state", 1, 32'(state_b), 32'd0);
      chk("clr_stopped_stop", 1, 32'(stop_b), 32'd0);

      // Saturating instance: 20 fails against a limit of 16, then passes continue.
      cyc();
      dut_valid = 4'hF;
      for (int k = 0; k < 5; k++) cyc();
      dut_valid = '0;
      chk("sat_fail_cnt", 0, 32'(fail_cnt_a), 32'd16);
      chk("sat_state", 0, 32'(state_a), 32'd1);
      exp_valid = 4'hF;
      exp_data  = {$urandom, $urandom};
      cyc();
      exp_valid = '0;
      dut_valid = 4'hF;
      for (int c = 0; c < CH; c++) drive_match(c, 1'b0);
      cyc();
      dut_valid = '0;
      chk("sat_pass_cnt", 0, pass_cnt_a, 32'd4);
      chk("sat_fail_hold", 0, 32'(fail_cnt_a), 32'd16);

      // Fill ch2 to depth in IDLE, then push and pop every cycle.
      clr = 1'b1;
      en  = 1'b0;
      cyc();
      clr = 1'b0;
      exp_valid = 4'b0100;
      for (int k = 0; k < DEPTH; k++) begin
         exp_data = {$urandom, $urandom};
         cyc();
         if (k == DEPTH - 2) chk("fill_ready_7", 0, 32'(exp_ready_a[2]), 32'd1);
      end
      chk("fill_ready_8", 0, 32'(exp_ready_a[2]), 32'd0);
      en = 1'b1;
      cyc();
      dut_valid = 4'b0100;
      for (int k = 0; k < 20; k++) begin
         exp_data = {$urandom, $urandom};
         drive_match(2, 1'b0);
         cyc();
      end
      dut_valid = '0;
      exp_valid = '0;
      chk("stream_pass", 0, pass_cnt_a, 32'd20);
      chk("stream_fail", 0, 32'(fail_cnt_a), 32'd0);

      // Random traffic, mostly matching, with occasional clears.
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      for (int k = 0; k < 400; k++) begin
         clr       = ($urandom_range(0, 49) == 0);
         exp_valid = 4'($urandom);
         exp_data  = {$urandom, $urandom};
         dut_valid = 4'($urandom) & 4'($urandom);
         for (int c = 0; c < CH; c++) drive_match(c, $urandom_range(0, 7) == 0);
         cyc();
      end
      clr = 1'b0;
      exp_valid = '0;
      dut_valid = '0;

      // Reset mid-run with a three-word backlog on ch0.
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      cyc();
      exp_valid = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         exp_data = {$urandom, $urandom};
         cyc();
      end
      exp_valid = '0;
      rst_n = 1'b0;
      #2;
      model_clear(0);
      model_clear(1);
      check_all();
      chk("rst_ready", 0, 32'(exp_ready_a), 32'hF);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
      dut_valid = 4'b0001;
      dut_data  = {$urandom, $urandom};
      cyc();
      dut_valid = '0;
      chk("rst_discard_uf", 0, 32'(underflow_a), 32'h1);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dutb_fail_monitor.md
# dutb_fail_monitor

Multi-channel, parametrised pass/fail monitor for the dutb environment, synthesisable so it can also run in emulation. Each channel buffers expected words in a small FIFO, compares them in order against DUT output words, and counts mismatches and underflows. When the aggregate failure count reaches the configured limit, the block halts the run (or keeps running with a saturated count) and drives `stop` to the testbench. It supersedes the fixed, single-threshold fail-limit constant with a per-instance, multi-channel counter that has selectable stop behaviour.

## Interface
Parameters:
- `P_CH_NUM`, 4: number of independent channels (1..16).
- `P_DATA_WIDTH`, 16: word width per channel.
- `P_EXP_DEPTH`, 8: expected-FIFO depth per channel; must be a power of 2, ≥2.
- `P_MAX_FAIL_NUM`, 16: failure limit (≥1).
- `P_STOP_MODE`, 1: 1 = halt at the limit; 0 = saturate the count and keep comparing.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: enables comparison.
- `clr`  in  1: synchronous clear of counters, FIFOs and state.
- `exp_valid`  in  P_CH_NUM: expected-word valid, one bit per channel.
- `exp_data`  in  P_CH_NUM×P_DATA_WIDTH: expected words.
- `exp_ready`  out  P_CH_NUM: FIFO can accept a word.
- `dut_valid`  in  P_CH_NUM: DUT output valid. There is no back-pressure on this input.
- `dut_data`  in  P_CH_NUM×P_DATA_WIDTH: DUT output words.
- `fail_cnt`  out  $clog2(P_MAX_FAIL_NUM+1): aggregate failures, saturating.
- `pass_cnt`  out  32: aggregate passing compares, wraps.
- `fail_mask`  out  P_CH_NUM: sticky per-channel "has failed" flags.
- `underflow`  out  P_CH_NUM: one-cycle pulse per underflow event.
- `stop`  out  1: limit reached (held high).
- `state`  out  2: FSM state.

## Operation
- FSM states:
  - IDLE (0).
  - RUN (1).
  - STOPPED (2).
- FSM transitions:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0.
  - RUN→STOPPED when the next `fail_cnt` ≥ P_MAX_FAIL_NUM and P_STOP_MODE=1.
  - Any state→IDLE on `clr`. `clr` has priority over every other event.
- `exp_ready[i]` = FIFO not full and state≠STOPPED. A push occurs on `exp_valid[i]`&`exp_ready[i]`, in any state other than STOPPED.
- When state=RUN and `dut_valid[i]`=1:
  - FIFO non-empty: pop the head and compare it with `dut_data[i]`. Equal counts as a pass; unequal counts as a fail.
  - FIFO empty: counts as a fail and pulses `underflow[i]`. Nothing is popped.
- `dut_valid` outside RUN is ignored. It is neither counted nor popped.
- Per cycle, `fail_cnt` increases by the popcount of failing channels and saturates at P_MAX_FAIL_NUM. `pass_cnt` increases by the popcount of passing channels.
- A push and a pop in the same cycle on the same channel:
  - Allowed whenever `exp_ready`=1.
  - The popped word is the old head.
  - A push into an empty FIFO is not visible to a same-cycle `dut_valid`; that case is an underflow.
- STOPPED holds all counters and FIFO contents frozen. Only `clr` or reset exits STOPPED.
- `clr` behaviour: empties FIFOs and zeroes `fail_cnt`, `pass_cnt`, `fail_mask` and `stop`.

## Timing
- Reset values:
  - `state`=IDLE.
  - `fail_cnt`=0, `pass_cnt`=0.
  - `fail_mask`=0, `underflow`=0, `stop`=0.
  - All FIFOs empty, so `exp_ready`=all ones.
- An asserted `rst_n` mid-run discards all FIFO contents immediately.
- Compare latency is 1 cycle. A `dut_valid` at edge N updates `fail_cnt`, `pass_cnt`, `fail_mask` and `underflow` at edge N+1.
- `stop` and the STOPPED state become visible at edge N+1 after the failing compare at N.
- `exp_ready` is registered from FIFO occupancy, so a full FIFO deasserts it in the cycle after the filling push.

## Structure
- Shared package `dutb_param_pkg` additions:
  - `dutb_mon_state_t` enum: IDLE, RUN, STOPPED.
  - Default constants for channel count, depth and stop mode.
- Sub-module `dutb_exp_fifo`:
  - One per channel.
  - Parametrised by width and depth.
  - Ports: push, pop, full, empty, head.
  - Pointers carry one extra wrap bit for the full/empty distinction.
- Top level contains the FSM, compare logic, popcount adders and counters.

## Test plan
- 2 channels, 8 matching words each → `pass_cnt`=16, `fail_cnt`=0, `stop`=0.
- Channel 0: word 3 corrupted; channel 1: 5 `dut_valid` with an empty FIFO → `fail_cnt`=6, `underflow[1]` pulses 5×, `fail_mask`=2'b11.
- P_MAX_FAIL_NUM=4, P_STOP_MODE=1, 4 channels failing in the same cycle → `fail_cnt`=4, `stop`=1 at the next edge, `exp_ready`=0; later `dut_valid` changes nothing.
- P_STOP_MODE=0, 20 fails with limit 16 → `fail_cnt`=16, `state` stays RUN, passes continue counting.
- Fill the FIFO to depth 8 → `exp_ready`=0; then push and pop each cycle → order is preserved, no loss.
- `clr` in STOPPED, then `rst_n` low during RUN with a 3-word backlog → all outputs at reset values, FIFOs empty.
